// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the branch redirect controller and its
// branch history table: FSM state encoding, 2-bit predictor counter type,
// counter reset value and saturating counter arithmetic.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    typedef logic [1:0] ctr_t;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam ctr_t CTR_RESET = 2'b01;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Branch history table: ENTRIES 2-bit saturating counters with one
// combinational read port (prediction = counter MSB) and one write port
// that nudges the addressed counter toward the resolved outcome.
// A same-cycle read of the entry being written returns the old value.
module branch_history_table
    import branch_ctrl_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_t ctr_q [ENTRIES];

    assign rd_taken = ctr_q[rd_idx][1];

    // Counter storage: reset every entry, then train the written entry.
    // NOTE: every entry is reset because the weakly-not-taken start state is
    // architecturally visible; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_taken ? ctr_inc(ctr_q[wr_idx]) : ctr_dec(ctr_q[wr_idx]);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end control-flow sequencer. Compares the EX-stage branch resolution
// with the fetch-time prediction; on a mispredict it flushes IF/ID, offers
// the corrected PC to fetch through a valid/ready handshake, then drains
// FLUSH_CYCLES wrong-path cycles before accepting new EX work.
// Build option: define BRANCH_BHT_EN to instantiate the branch history
// table; otherwise fetch predicts statically not-taken.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;

    logic             actual;
    logic             mispredict;
    logic             idle;
    logic             bht_update;
    logic [XLEN-1:0]  correct_pc;
    logic             if_pc_unused;

    assign actual     = ex_jump | (ex_branch & ex_taken);
    assign mispredict = ex_valid & (ex_branch | ex_jump) & (actual != ex_pred_taken);
    assign correct_pc = actual ? ex_target : ex_pc + XLEN'(4);
    assign idle       = (state == ST_IDLE);
    // Mispredict flush must hit IF/ID in the resolving cycle itself.
    assign flush      = ~idle | mispredict;
    // Outside IDLE the EX stage holds wrong-path work, so it never trains.
    assign bht_update = idle & ex_valid & ex_branch;

    // Redirect sequencer: capture the corrected PC, hold it until fetch
    // accepts, then count out the drain window.
    // NOTE: state is updated with non-blocking assignments so every branch
    // of the case sees the pre-edge values of state and drain_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            drain_cnt        <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mispredict) begin
                        redirect_pc      <= correct_pc;
                        redirect_valid   <= 1'b1;
                        mispredict_count <= mispredict_count + 32'd1;
                        state            <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        drain_cnt      <= DRAIN_LOAD;
                        state          <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_BHT_EN
    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (if_pred_taken),
        .wr_en    (bht_update),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (ex_taken)
    );

    // Only the index bits of the fetch PC select a counter.
    assign if_pc_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};
`else
    // Static not-taken prediction; training requests go nowhere.
    assign if_pred_taken = 1'b0;
    assign if_pc_unused  = ^{if_pc, bht_update};
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Front-end control-flow sequencer for the RV32 core. It takes the EX-stage resolution from the branch unit and compares it with the prediction carried down the pipe. On a mispredict it sequences the redirect handshake to fetch and squashes wrong-path IF/ID work. It also hosts the branch history table that supplies fetch-time predictions.

## Interface
- `XLEN`, 32, address width
- `BHT_ENTRIES`, 64, BHT depth; power of two, ≥2
- `FLUSH_CYCLES`, 2, post-redirect drain length; ≥1
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `ex_valid` in 1: EX holds a valid instruction this cycle
- `ex_branch` in 1: conditional branch (CU branch_enable)
- `ex_jump` in 1: JAL/JALR, always taken
- `ex_taken` in 1: branch unit branch_taken
- `ex_pred_taken` in 1: prediction made at fetch for this instruction
- `ex_pc` in XLEN: PC of EX instruction
- `ex_target` in XLEN: computed target
- `if_pc` in XLEN: fetch PC for prediction lookup
- `if_pred_taken` out 1: combinational prediction for `if_pc`
- `redirect_valid` out 1: redirect request to fetch
- `redirect_pc` out XLEN: corrected PC
- `redirect_ready` in 1: fetch accepts redirect
- `flush` out 1: kill IF/ID contents
- `mispredict_count` out 32: performance counter

## Operation
- `actual = ex_jump | (ex_branch & ex_taken)`; `mispredict = ex_valid & (ex_branch | ex_jump) & (actual != ex_pred_taken)`.
- `correct_pc = actual ? ex_target : ex_pc + 4`, mod 2^XLEN.
- FSM states: IDLE, REDIRECT, DRAIN.
- IDLE:
  - EX inputs evaluated.
  - On `mispredict`: `flush`=1 combinationally in the same cycle; `correct_pc` registered; count incremented; → REDIRECT.
- REDIRECT:
  - `redirect_valid`=1, `flush`=1, `redirect_pc` held stable; EX inputs ignored.
  - On `redirect_ready`: load drain counter with FLUSH_CYCLES−1; → DRAIN.
- DRAIN:
  - `flush`=1, `redirect_valid`=0; EX inputs ignored (wrong path).
  - Counter decrements each cycle; at 0 → IDLE.
- BHT update: in IDLE only, when `ex_valid & ex_branch` (not jumps), the 2-bit saturating counter at index `ex_pc[log2(BHT_ENTRIES)+1:2]` moves toward `ex_taken`. Updates happen whether or not the branch mispredicted.
- Lookup: `if_pred_taken` = counter[1] at `if_pc[log2(BHT_ENTRIES)+1:2]`. A same-cycle read and write to the same index returns the old value.
- `mispredict_count` wraps at 2^32.

## Timing
- Reset values:
  - FSM=IDLE; `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `mispredict_count`=0.
  - All BHT counters=2'b01 (weakly not-taken).
- Mispredict in EX cycle N: `flush` high in N; `redirect_valid` high from N+1 until the cycle `redirect_ready` is sampled high (inclusive).
- With `redirect_ready` held high: redirect accepted at N+1; `flush` high N..N+1+FLUSH_CYCLES; IDLE at N+2+FLUSH_CYCLES.
- Handshake: once asserted, `redirect_valid`/`redirect_pc` do not change until accepted.
- `redirect_ready` is ignored outside REDIRECT.
- Reset asserted mid-sequence returns immediately to IDLE with all reset values, including the BHT.

## Configuration
- `BRANCH_BHT_EN` defined: BHT instantiated as above.
- `BRANCH_BHT_EN` undefined:
  - No BHT storage; `if_pred_taken` tied 0 (static not-taken); BHT updates are no-ops.
  - Redirect FSM and counter are unchanged.

## Structure
- `branch_ctrl_pkg` holds:
  - the FSM state enum
  - the 2-bit counter typedef
  - the counter reset constant (2'b01)
  - saturating increment/decrement functions
- The BHT is a natural sub-module, `branch_history_table`: one read port, one write port, async reset of all entries. It is instantiated only under `BRANCH_BHT_EN`.

## Test plan
- BEQ at pc 0x100, `ex_taken`=1, `ex_pred_taken`=0, target 0x200, `redirect_ready`=1 → `flush` in N; `redirect_valid`, `redirect_pc`=0x200 in N+1; IDLE at N+4 (FLUSH_CYCLES=2); count=1.
- Branch at 0x100 not taken, predicted taken → `redirect_pc`=0x104.
- `redirect_ready` held low 5 cycles → `redirect_valid` and `redirect_pc` stable for all 5; EX inputs with a mispredict during the wait cause no count change.
- Four taken BEQs at 0x40 (correctly predicted) → `if_pred_taken` at `if_pc`=0x40 goes 0→1 after the first update; counter saturates at 2'b11; one not-taken update keeps the prediction 1.
- JAL with `ex_pred_taken`=1 → no redirect, BHT unchanged. JAL with `ex_pred_taken`=0 → redirect to `ex_target`.
- Reset asserted during DRAIN → all outputs 0 asynchronously; `if_pred_taken`=0 for every index.
